// File: rtl/key_pulse_gen_pkg.sv
// key_pulse_gen_pkg: shared types for the button front end.
// FSM state encoding, key index names, counter width helper.
package key_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int KEY_CAT   = 3;
  localparam int KEY_DOG   = 2;
  localparam int KEY_MOUSE = 1;
  localparam int KEY_CANOE = 0;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_pulse_gen_debounce.sv
// key_debounce: 2-FF sync, polarity normalize, debounce, press event.
// Ports: clk_1kHz, rst (async high), btn_raw in; press out (1 cycle).
module key_debounce
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 20,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk_1kHz,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          synced;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Sync FFs reset to the raw released level so reset never
  // looks like a press to the debouncer.
  assign synced = sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      sync1    <= ACTIVE_LOW;
      sync2    <= ACTIVE_LOW;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Only the released->pressed transition is an event.
  assign press = stable & ~stable_d;

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounced, prioritized, stretched button pulses.
// Ports: clk_1kHz, rst, btn_in[N] in; btn_out[N], pending[N], busy out.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CNT = 20,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic              clk_1kHz,
  input  logic              rst,
  input  logic [N_KEYS-1:0] btn_in,
  output logic [N_KEYS-1:0] btn_out,
  output logic [N_KEYS-1:0] pending,
  output logic              busy
);

  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  logic [N_KEYS-1:0] press;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_deb (
      .clk_1kHz(clk_1kHz),
      .rst     (rst),
      .btn_raw (btn_in[k]),
      .press   (press[k])
    );
  end

  state_t            state;
  state_t            state_n;
  logic [N_KEYS-1:0] sel;
  logic [N_KEYS-1:0] sel_n;
  logic [N_KEYS-1:0] hi;
  logic [N_KEYS-1:0] clr;
  logic [N_KEYS-1:0] pending_n;
  logic [N_KEYS-1:0] btn_out_n;
  logic [PW-1:0]     pcnt;
  logic [PW-1:0]     pcnt_n;
  logic [GW-1:0]     gcnt;
  logic [GW-1:0]     gcnt_n;

  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      pcnt    <= '0;
      gcnt    <= '0;
      btn_out <= '0;
      pending <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      pcnt    <= pcnt_n;
      gcnt    <= gcnt_n;
      btn_out <= btn_out_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    pcnt_n    = pcnt;
    gcnt_n    = gcnt;
    btn_out_n = '0;
    clr       = '0;
    hi        = '0;
    // Highest set index wins; later iterations override.
    for (int i = 0; i < N_KEYS; i++) begin
      if (pending[i]) begin
        hi    = '0;
        hi[i] = 1'b1;
      end
    end
    unique case (state)
      IDLE: begin
        if (|pending) begin
          sel_n     = hi;
          clr       = hi;
          state_n   = PULSE;
          pcnt_n    = '0;
          btn_out_n = hi;
        end
      end
      PULSE: begin
        if (pcnt == P_LAST) begin
          state_n = GAP;
          gcnt_n  = '0;
        end else begin
          pcnt_n    = pcnt + 1'b1;
          btn_out_n = sel;
        end
      end
      GAP: begin
        if (gcnt == G_LAST) begin
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A new press beats the dispatch clear, even for the same key.
    pending_n = (pending & ~clr) | press;
  end

  assign busy = (state != IDLE) | (|pending);

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: scoreboard bench for key_pulse_gen.
// Three instances: defaults, active-low fast, short debounce.
module tb_key_pulse_gen;
  import key_pulse_gen_pkg::*;

  typedef struct {
    logic [3:0] val;
    int         start;
    int         width;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_a, btn_b, btn_c;
  logic [3:0] out_a, out_b, out_c;
  logic [3:0] pend_a, pend_b, pend_c;
  logic       busy_a, busy_b, busy_c;
  logic [3:0] outs [3];

  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  pulse_t sbq [3][$];
  logic [3:0] run_val [3];
  int     run_start [3];
  int     run_len [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_pulse_gen u_a (
    .clk_1kHz(clk), .rst(rst), .btn_in(btn_a),
    .btn_out(out_a), .pending(pend_a), .busy(busy_a)
  );

  key_pulse_gen #(
    .DEBOUNCE_CNT(1), .PULSE_CYCLES(1), .ACTIVE_LOW(1'b1)
  ) u_b (
    .clk_1kHz(clk), .rst(rst), .btn_in(btn_b),
    .btn_out(out_b), .pending(pend_b), .busy(busy_b)
  );

  key_pulse_gen #(
    .DEBOUNCE_CNT(2)
  ) u_c (
    .clk_1kHz(clk), .rst(rst), .btn_in(btn_c),
    .btn_out(out_c), .pending(pend_c), .busy(busy_c)
  );

  assign outs[0] = out_a;
  assign outs[1] = out_b;
  assign outs[2] = out_c;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d @cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic push(int d, logic [3:0] v, int s, int w);
    pulse_t e;
    e.val = v;
    e.start = s;
    e.width = w;
    sbq[d].push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic close_run(int d);
    pulse_t e;
    check($sformatf("d%0d_sb_has_entry", d),
          int'(sbq[d].size() != 0), 1);
    if (sbq[d].size() != 0) begin
      e = sbq[d].pop_front();
      check($sformatf("d%0d_val", d),
            int'(run_val[d]), int'(e.val));
      check($sformatf("d%0d_start", d),
            run_start[d], e.start);
      check($sformatf("d%0d_width", d),
            run_len[d], e.width);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      run_val[d] = '0;
      run_start[d] = 0;
      run_len[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (outs[d] != 4'b0)
        check($sformatf("d%0d_onehot", d),
              $countones(outs[d]), 1);
      if (outs[d] != run_val[d]) begin
        if (run_val[d] != 4'b0) close_run(d);
        run_val[d] = outs[d];
        run_start[d] = cyc;
        run_len[d] = 1;
      end else if (run_val[d] != 4'b0) begin
        run_len[d]++;
      end
    end
  end

  task automatic drain();
    int k = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0
           || busy_a || busy_b || busy_c) begin
      if (k >= 300) break;
      step(1);
      k++;
    end
    check("drain_in_time", int'(k < 300), 1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    btn_a = 4'b0000;
    btn_b = 4'b1111;
    btn_c = 4'b0000;
    step(3);
    check("rst_out_a", int'(out_a), 0);
    check("rst_pend_a", int'(pend_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_out_b", int'(out_b), 0);
    check("rst_pend_b", int'(pend_b), 0);
    check("rst_busy_c", int'(busy_c), 0);
    rst = 1'b0;
    step(5);

    // clean press of key2, held 100 cycles
    btn_a = 4'b0100;
    t = cyc + 1;
    push(0, 4'b0100, t + 23, 4);
    step(100);
    btn_a = 4'b0000;
    step(40);
    drain();

    // key1 bounce, then settle high
    for (int i = 0; i < 8; i++) begin
      btn_a[KEY_MOUSE] = (i % 2 == 0);
      step(5);
    end
    btn_a[KEY_MOUSE] = 1'b1;
    t = cyc + 1;
    push(0, 4'b0010, t + 23, 4);
    step(60);
    btn_a = 4'b0000;
    step(40);
    drain();

    // keys 3,1,0 on one edge
    btn_a = 4'b1011;
    t = cyc + 1;
    push(0, 4'b1000, t + 23, 4);
    push(0, 4'b0010, t + 30, 4);
    push(0, 4'b0001, t + 37, 4);
    step(43);
    check("busy_last_gap", int'(busy_a), 1);
    btn_a = 4'b0000;
    step(1);
    check("busy_after_gap", int'(busy_a), 0);
    step(40);
    drain();

    // key0 pressed twice while pending (debounce 2)
    btn_c = 4'b1100;
    t = cyc + 1;
    push(2, 4'b1000, t + 5, 4);
    push(2, 4'b0100, t + 12, 4);
    push(2, 4'b0001, t + 19, 4);
    step(2);
    btn_c = 4'b1101;
    step(3);
    btn_c = 4'b1100;
    step(3);
    btn_c = 4'b1101;
    step(11);
    check("pend0_before_dispatch", int'(pend_c[KEY_CANOE]), 1);
    step(1);
    check("pend0_at_dispatch", int'(pend_c[KEY_CANOE]), 0);
    step(10);
    btn_c = 4'b0000;
    step(20);
    drain();

    // reset mid-pulse with key2 held
    btn_a = 4'b0100;
    t = cyc + 1;
    push(0, 4'b0100, t + 23, 1);
    push(0, 4'b0100, t + 49, 4);
    step(25);
    rst = 1'b1;
    #1;
    check("rst_async_out", int'(out_a), 0);
    check("rst_async_pend", int'(pend_a), 0);
    check("rst_async_busy", int'(busy_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(40);
    btn_a = 4'b0000;
    step(40);
    drain();

    // active low, fast params
    btn_b[KEY_MOUSE] = 1'b0;
    t = cyc + 1;
    push(1, 4'b0010, t + 4, 1);
    step(10);
    btn_b = 4'b1111;
    step(10);
    drain();

    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d_sb_empty", d), sbq[d].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
